// File: rtl/lock_monitor_pkg.sv
// ============================================================================
// Module   : lock_monitor_pkg
// Brief    : State encoding and decode helper shared by the lock supervisor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lock_monitor_pkg;

    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED   = 2'd2;
    localparam logic [1:0] c_ST_GRACE    = 2'd3;

    // LOCKED and GRACE both count as "in lock" for the LEDs and the timer.
    function automatic logic is_engaged(input logic [1:0] st);
        return (st == c_ST_LOCKED) || (st == c_ST_GRACE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lm_down_timer.sv
// ============================================================================
// Module   : lm_down_timer
// Brief    : Relock indicator timer; load/decrement/clear, drives active-low LED.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lm_down_timer #(
    parameter int INDICATE_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_active,
    output logic o_relocked_n
);

    localparam int c_TMR_W = $clog2(INDICATE_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(INDICATE_CYCLES - 1);

    logic [c_TMR_W-1:0] r_timer_q;
    logic [c_TMR_W-1:0] w_timer_d;
    logic               r_relocked_n_q;
    logic               w_relocked_n_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_q      <= '0;
            r_relocked_n_q <= 1'b1;
        end else begin
            r_timer_q      <= w_timer_d;
            r_relocked_n_q <= w_relocked_n_d;
        end
    end

    // The LED stays lit through the cycle in which the count reaches zero,
    // giving exactly INDICATE_CYCLES lit cycles per load.
    always_comb begin
        w_timer_d = r_timer_q;
        if (i_clear) begin
            w_timer_d = '0;
        end else if (i_load) begin
            w_timer_d = c_TMR_LOAD;
        end else if (i_active && (r_timer_q != '0)) begin
            w_timer_d = r_timer_q - c_TMR_W'(1);
        end
        w_relocked_n_d = !(i_active && (i_load || (r_timer_q != '0)));
    end

    assign o_relocked_n = r_relocked_n_q;

endmodule

`default_nettype wire

// File: rtl/lock_monitor.sv
// ============================================================================
// Module   : lock_monitor
// Brief    : Debounced lock supervisor driving PID enable, sweep hold and LEDs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lock_monitor
    import lock_monitor_pkg::*;
#(
    parameter int ACQ_CYCLES      = 1000,
    parameter int DROP_CYCLES     = 16,
    parameter int INDICATE_CYCLES = 100_000_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [15:0] trans_in,
    input  logic signed [15:0] lock_thresh,
    input  logic signed [15:0] unlock_thresh,
    output logic               pid_on_out,
    output logic               sweep_hold_out,
    output logic               locked_n_out,
    output logic               unlocked_n_out,
    output logic               relocked_n_out,
    output logic [1:0]         state_out,
    output logic [15:0]        loss_count_out
);

    localparam int c_CNT_MAX = (ACQ_CYCLES > DROP_CYCLES) ? ACQ_CYCLES : DROP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_ACQ_LAST  = c_CNT_W'(ACQ_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DROP_LAST = c_CNT_W'(DROP_CYCLES - 1);

    logic signed [15:0] r_trans_q, w_trans_d;
    logic [1:0]         r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [15:0]        r_loss_q, w_loss_d;
    logic               r_pid_on_q, w_pid_on_d;
    logic               r_locked_n_q, w_locked_n_d;
    logic               r_unlocked_n_q, w_unlocked_n_d;
    logic               w_tmr_load, w_tmr_clear, w_tmr_active;
    logic               w_above_lock, w_below_unlock;

    assign w_above_lock   = (r_trans_q >= lock_thresh);
    assign w_below_unlock = (r_trans_q < unlock_thresh);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_trans_q      <= '0;
            r_state_q      <= c_ST_UNLOCKED;
            r_cnt_q        <= '0;
            r_loss_q       <= '0;
            r_pid_on_q     <= 1'b0;
            r_locked_n_q   <= 1'b1;
            r_unlocked_n_q <= 1'b0;
        end else begin
            r_trans_q      <= w_trans_d;
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_loss_q       <= w_loss_d;
            r_pid_on_q     <= w_pid_on_d;
            r_locked_n_q   <= w_locked_n_d;
            r_unlocked_n_q <= w_unlocked_n_d;
        end
    end

    // The shared counter is cleared on every state change.
    always_comb begin
        w_trans_d  = trans_in;
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_loss_d   = r_loss_q;
        w_tmr_load = 1'b0;
        case (r_state_q)
            c_ST_UNLOCKED: begin
                if (w_above_lock) begin
                    w_state_d = c_ST_ACQUIRE;
                    w_cnt_d   = '0;
                end
            end
            c_ST_ACQUIRE: begin
                if (!w_above_lock) begin
                    w_state_d = c_ST_UNLOCKED;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_ACQ_LAST) begin
                    w_state_d  = c_ST_LOCKED;
                    w_cnt_d    = '0;
                    w_tmr_load = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
            c_ST_LOCKED: begin
                if (w_below_unlock) begin
                    w_state_d = c_ST_GRACE;
                    w_cnt_d   = '0;
                end
            end
            c_ST_GRACE: begin
                if (!w_below_unlock) begin
                    w_state_d = c_ST_LOCKED;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_DROP_LAST) begin
                    w_state_d = c_ST_UNLOCKED;
                    w_cnt_d   = '0;
                    if (r_loss_q != 16'hFFFF) begin
                        w_loss_d = r_loss_q + 16'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_d = c_ST_UNLOCKED;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they update with the state register.
    always_comb begin
        w_pid_on_d     = (w_state_d != c_ST_UNLOCKED);
        w_locked_n_d   = !is_engaged(w_state_d);
        w_unlocked_n_d = (w_state_d != c_ST_UNLOCKED);
        w_tmr_clear    = (w_state_d == c_ST_UNLOCKED);
        w_tmr_active   = is_engaged(w_state_d);
    end

    lm_down_timer #(
        .INDICATE_CYCLES (INDICATE_CYCLES)
    ) u_timer (
        .clk          (clk_in),
        .rst          (rst_in),
        .i_load       (w_tmr_load),
        .i_clear      (w_tmr_clear),
        .i_active     (w_tmr_active),
        .o_relocked_n (relocked_n_out)
    );

    assign pid_on_out     = r_pid_on_q;
    assign sweep_hold_out = r_pid_on_q;
    assign locked_n_out   = r_locked_n_q;
    assign unlocked_n_out = r_unlocked_n_q;
    assign state_out      = r_state_q;
    assign loss_count_out = r_loss_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_monitor.sv
// ============================================================================
// Module   : tb_lock_monitor
// Brief    : Directed self-checking bench for lock_monitor (ACQ=4, DROP=3, IND=10).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lock_monitor;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] trans_in;
    logic signed [15:0] lock_thresh;
    logic signed [15:0] unlock_thresh;
    logic               pid_on, sweep_hold, locked_n, unlocked_n, relocked_n;
    logic [1:0]         state;
    logic [15:0]        loss_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lock_monitor #(
        .ACQ_CYCLES      (4),
        .DROP_CYCLES     (3),
        .INDICATE_CYCLES (10)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .trans_in       (trans_in),
        .lock_thresh    (lock_thresh),
        .unlock_thresh  (unlock_thresh),
        .pid_on_out     (pid_on),
        .sweep_hold_out (sweep_hold),
        .locked_n_out   (locked_n),
        .unlocked_n_out (unlocked_n),
        .relocked_n_out (relocked_n),
        .state_out      (state),
        .loss_count_out (loss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic e_pid, input logic e_lk_n,
                            input logic e_ul_n, input logic e_rl_n, input logic [1:0] e_st);
        chk({tag, ".pid_on"},     pid_on,     e_pid);
        chk({tag, ".sweep_hold"}, sweep_hold, e_pid);
        chk({tag, ".locked_n"},   locked_n,   e_lk_n);
        chk({tag, ".unlocked_n"}, unlocked_n, e_ul_n);
        chk({tag, ".relocked_n"}, relocked_n, e_rl_n);
        chk({tag, ".state"},      state,      e_st);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
        int n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, state, target);
    endtask

    initial begin
        rst           = 1'b1;
        trans_in      = 16'sd0;
        lock_thresh   = 16'sd8000;
        unlock_thresh = 16'sd6000;
        tick();
        tick();
        chk_outs("reset", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        chk("reset.loss", loss_count, 16'd0);

        // Acquisition: ACQUIRE at edge 2, LOCKED at edge 6, LED lit 10 cycles.
        rst      = 1'b0;
        trans_in = 16'sd9000;
        tick();
        chk_outs("edge1", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        tick();
        chk_outs("edge2", 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        tick(); tick(); tick();
        chk("edge5.state", state, 2'd1);
        tick();
        chk_outs("edge6", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        for (int i = 7; i <= 15; i++) begin
            tick();
            chk("relock_led_on", relocked_n, 1'b0);
        end
        tick();
        chk_outs("edge16", 1'b1, 1'b0, 1'b1, 1'b1, 2'd2);

        // Two low samples then recovery: GRACE and back, no loss.
        trans_in = 16'sd5000;
        tick();
        chk("g17.state", state, 2'd2);
        tick();
        chk_outs("g18", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        trans_in = 16'sd7000;
        tick();
        chk("g19.state", state, 2'd3);
        tick();
        chk_outs("g20", 1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
        chk("g20.loss", loss_count, 16'd0);

        // Sustained low: GRACE at edge 22, UNLOCKED three edges later.
        trans_in = 16'sd5000;
        tick(); tick();
        chk("l22.state", state, 2'd3);
        tick(); tick();
        chk("l24.state", state, 2'd3);
        tick();
        chk_outs("l25", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        chk("l25.loss", loss_count, 16'd1);

        // One low sample during ACQUIRE aborts; a fresh 5-sample run is needed.
        trans_in = 16'sd9000;
        tick(); tick();
        chk("a27.state", state, 2'd1);
        trans_in = 16'sd7000;
        tick();
        chk("a28.state", state, 2'd1);
        trans_in = 16'sd9000;
        tick();
        chk_outs("a29", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        tick();
        chk("a30.state", state, 2'd1);
        tick(); tick(); tick();
        chk("a33.state", state, 2'd1);
        tick();
        chk_outs("a34", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);

        // Saturation of the loss counter.
        force dut.r_loss_q = 16'hFFFE;
        #1;
        release dut.r_loss_q;
        trans_in = 16'sd5000;
        wait_state("sat1.unlock", 2'd0, 10);
        chk("sat1.loss", loss_count, 16'hFFFF);
        trans_in = 16'sd9000;
        wait_state("sat.relock", 2'd2, 20);
        trans_in = 16'sd5000;
        wait_state("sat2.unlock", 2'd0, 10);
        chk("sat2.loss", loss_count, 16'hFFFF);
        chk("sat2.unlocked_n", unlocked_n, 1'b0);

        // Reset mid-ACQUIRE.
        trans_in = 16'sd9000;
        wait_state("r1.acq", 2'd1, 10);
        tick();
        rst = 1'b1;
        tick();
        chk_outs("r1", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        chk("r1.loss", loss_count, 16'd0);
        rst = 1'b0;

        // Reset mid-GRACE.
        wait_state("r2.lock", 2'd2, 20);
        trans_in = 16'sd5000;
        wait_state("r2.grace", 2'd3, 10);
        tick();
        rst = 1'b1;
        tick();
        chk_outs("r2", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
